// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory read arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE)
//   REQ_IDX_W   : width of a requester index, sized for the largest
//                 supported requester count (8)
//   STAT_W      : width of each per-requester grant counter
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    localparam int REQ_IDX_W = $clog2(8);
    localparam int STAT_W    = 16;

endpackage

// File: rtl/rd_id_fifo.sv
// rd_id_fifo: DEPTH-entry synchronous FIFO of requester indices. It remembers
// which requester issued each outstanding read so that in-order responses can
// be routed back to it.
// Ports:
//   clk, rst   clock, synchronous active-high reset (FIFO becomes empty)
//   push       write push_idx (ignored when full)
//   push_idx   requester index to store
//   pop        drop the head entry (ignored when empty)
//   head_idx   index at the head of the FIFO
//   count      number of valid entries (0..DEPTH)
// A push and a pop in the same cycle leave count unchanged.
module rd_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [REQ_IDX_W-1:0]   push_idx,
    input  logic                   pop,
    output logic [REQ_IDX_W-1:0]   head_idx,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REQ_IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 do_push;
    logic                 do_pop;

    assign do_push  = push && (count_q != CNT_W'(DEPTH));
    assign do_pop   = pop && (count_q != '0);
    assign head_idx = mem_q[rd_ptr_q];
    assign count    = count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one Avalon-MM read master among NUM_REQ requesters.
// Round-robin grant, up to MAX_OUTST pipelined reads in flight, in-order
// response routing back to the issuing requester.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_read            per-requester read strobe
//   req_address         requester i address at [i*ADDR_W +: ADDR_W]
//   req_waitrequest     low for one cycle when requester's read is accepted
//   req_readdata        broadcast copy of mem_readdata
//   req_readdatavalid   one-hot: response belongs to requester i
//   mem_*               Avalon-MM read master towards the memory slave
//   protocol_err        sticky: readdatavalid seen with nothing outstanding
//   stat_grants         (MEM_RD_ARB_STATS_EN only) 16-bit saturating
//                       accepted-read counter per requester
// Build option: define MEM_RD_ARB_STATS_EN to add the grant counters.
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_read,
    input  logic [DATA_W-1:0]         mem_readdata,
    input  logic                      mem_readdatavalid,
    input  logic                      mem_waitrequest,
    output logic                      protocol_err
`ifdef MEM_RD_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_grants
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    arb_state_e           state_q, state_d;
    logic [REQ_IDX_W-1:0] grant_q;
    logic [REQ_IDX_W-1:0] last_grant_q;
    logic [REQ_IDX_W-1:0] winner;
    logic                 found;
    logic                 accept;
    logic                 pop;
    logic [REQ_IDX_W-1:0] head_idx;
    logic [CNT_W-1:0]     fifo_count;

    assign accept = (state_q == ISSUE) && !mem_waitrequest;
    assign pop    = mem_readdatavalid && (fifo_count != '0);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_read[cand]) begin
                found  = 1'b1;
                winner = REQ_IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found && (fifo_count < CNT_W'(MAX_OUTST))) state_d = ISSUE;
            ISSUE:   if (!mem_waitrequest) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (grant_q == REQ_IDX_W'(i))) req_waitrequest[i]   = 1'b0;
            if (pop && (head_idx == REQ_IDX_W'(i)))   req_readdatavalid[i] = 1'b1;
        end
    end

    assign req_readdata = mem_readdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= '0;
            last_grant_q <= REQ_IDX_W'(NUM_REQ - 1);
            mem_address  <= '0;
            mem_read     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == ISSUE) begin
                grant_q     <= winner;
                mem_address <= req_address[int'(winner)*ADDR_W +: ADDR_W];
                mem_read    <= 1'b1;
            end
            if (accept) begin
                last_grant_q <= grant_q;
                mem_read     <= 1'b0;
            end
            if (mem_readdatavalid && fifo_count == '0)
                protocol_err <= 1'b1;
        end
    end

    rd_id_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_idx(grant_q),
        .pop     (pop),
        .head_idx(head_idx),
        .count   (fifo_count)
    );

`ifdef MEM_RD_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant_q == REQ_IDX_W'(i) && stat_q[i] != '1)
                    stat_q[i] <= stat_q[i] + 1'b1;
        end
    end

    assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter (NUM_REQ=2, MAX_OUTST=4). Inputs change
// 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_mem_rd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_read;
    logic [ADDR_W-1:0]         addr0, addr1;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;
    logic [ADDR_W-1:0]         mem_address;
    logic                      mem_read;
    logic [DATA_W-1:0]         mem_readdata;
    logic                      mem_readdatavalid;
    logic                      mem_waitrequest;
    logic                      protocol_err;
`ifdef MEM_RD_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     stat_grants;
`endif

    int total = 0;
    int bad   = 0;

    assign req_address = {addr1, addr0};

    always #5 clk = ~clk;

    mem_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_read         (req_read),
        .req_address      (req_address),
        .req_waitrequest  (req_waitrequest),
        .req_readdata     (req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_readdata     (mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .mem_waitrequest  (mem_waitrequest),
        .protocol_err     (protocol_err)
`ifdef MEM_RD_ARB_STATS_EN
        ,
        .stat_grants      (stat_grants)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        req_read          = '0;
        addr0             = '0;
        addr1             = '0;
        mem_readdata      = '0;
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b0;

        // Reset state
        do_reset();
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_waitreq", req_waitrequest, 2'b11);
        chk("rst_rdv", req_readdatavalid, 0);
        chk("rst_perr", protocol_err, 0);

        // 1: single requester
        req_read = 2'b01; addr0 = 32'h10;
        #1;
        chk("t1_idle_wait", req_waitrequest, 2'b11);
        chk("t1_idle_read", mem_read, 0);
        tick();
        chk("t1_iss_read", mem_read, 1);
        chk("t1_iss_addr", mem_address, 32'h10);
        chk("t1_iss_wait", req_waitrequest, 2'b10);
        req_read = 2'b00;
        tick();
        chk("t1_post_read", mem_read, 0);
        chk("t1_post_wait", req_waitrequest, 2'b11);
        tick();
        mem_readdatavalid = 1'b1; mem_readdata = 64'hAA;
        #1;
        chk("t1_rdv", req_readdatavalid, 2'b01);
        chk("t1_data", req_readdata, 64'hAA);
        tick();
        mem_readdatavalid = 1'b0;
        #1;
        chk("t1_perr", protocol_err, 0);

        // 2: both requesters, round robin 0,1,0,1
        do_reset();
        req_read = 2'b11; addr0 = 32'h100; addr1 = 32'h200;
        #1;
        chk("t2_idle_wait", req_waitrequest, 2'b11);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_iss_read", mem_read, 1);
            chk("t2_iss_addr", mem_address, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("t2_iss_wait", req_waitrequest, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            chk("t2_idle_read", mem_read, 0);
        end
        req_read = 2'b00;
        for (int k = 0; k < 4; k++) begin
            mem_readdatavalid = 1'b1; mem_readdata = 64'h1000 + 64'(k);
            #1;
            chk("t2_rdv", req_readdatavalid, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_data", req_readdata, 64'h1000 + 64'(k));
            tick();
        end
        mem_readdatavalid = 1'b0;

        // 4: outstanding limit
        req_read = 2'b01; addr0 = 32'h300;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_iss_wait", req_waitrequest, 2'b10);
            tick();
            chk("t4_idle_read", mem_read, 0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_full_read", mem_read, 0);
            chk("t4_full_wait", req_waitrequest, 2'b11);
        end
        mem_readdatavalid = 1'b1; mem_readdata = 64'h55;
        #1;
        chk("t4_pop_rdv", req_readdatavalid, 2'b01);
        chk("t4_pop_data", req_readdata, 64'h55);
        tick();
        mem_readdatavalid = 1'b0;
        #1;
        chk("t4_after_pop_read", mem_read, 0);
        tick();
        chk("t4_5th_read", mem_read, 1);
        chk("t4_5th_addr", mem_address, 32'h300);
        chk("t4_5th_wait", req_waitrequest, 2'b10);
        req_read = 2'b00;
        tick();
        chk("t4_5th_done", mem_read, 0);
        for (int k = 0; k < 4; k++) begin
            mem_readdatavalid = 1'b1;
            #1;
            chk("t4_drain_rdv", req_readdatavalid, 2'b01);
            tick();
        end
        mem_readdatavalid = 1'b0;

        // 3: slave waitrequest held 5 cycles
        req_read = 2'b10; addr1 = 32'h400; mem_waitrequest = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_read", mem_read, 1);
            chk("t3_hold_addr", mem_address, 32'h400);
            chk("t3_hold_wait", req_waitrequest, 2'b11);
            tick();
        end
        mem_waitrequest = 1'b0;
        #1;
        chk("t3_rel_wait", req_waitrequest, 2'b01);
        req_read = 2'b00;
        tick();
        chk("t3_rel_read", mem_read, 0);
        mem_readdatavalid = 1'b1; mem_readdata = 64'h77;
        #1;
        chk("t3_rdv", req_readdatavalid, 2'b10);
        chk("t3_data", req_readdata, 64'h77);
        tick();
        chk("t3_extra_rdv", req_readdatavalid, 2'b00);
        tick();
        mem_readdatavalid = 1'b0;
        #1;
        chk("t3_extra_perr", protocol_err, 1);

        // 5: stray response after reset
        do_reset();
        #1;
        chk("t5_perr_clr", protocol_err, 0);
        mem_readdatavalid = 1'b1;
        #1;
        chk("t5_rdv", req_readdatavalid, 2'b00);
        tick();
        mem_readdatavalid = 1'b0;
        #1;
        chk("t5_perr_set", protocol_err, 1);
        tick();
        tick();
        chk("t5_perr_sticky", protocol_err, 1);
        do_reset();
        #1;
        chk("t5_perr_rst", protocol_err, 0);

`ifdef MEM_RD_ARB_STATS_EN
        // 6: grant counters
        req_read = 2'b10; addr1 = 32'h500;
        for (int k = 0; k < 10; k++) begin
            tick();
            mem_readdatavalid = 1'b0;
            if (k == 9) req_read = 2'b00;
            tick();
            mem_readdatavalid = 1'b1;
        end
        tick();
        mem_readdatavalid = 1'b0;
        #1;
        chk("t6_stats", stat_grants, {16'd10, 16'd0});
        chk("t6_perr", protocol_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
